// File: rtl/fifo_pkg.sv
// Shared definitions for the 128-bit sync FIFO and its read-side unpacker.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 128;
  localparam int unsigned UNPK_OUT_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } unpk_state_t;

endpackage

// File: rtl/fifo_rd_unpacker.sv
// Read-side unpacker: pops one FIFO word at a time and streams it out as OUT_W-bit beats,
// least-significant lane first, with at most one read outstanding.
module fifo_rd_unpacker
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned OUT_W  = UNPK_OUT_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  output logic              o_fifo_rden,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_word_cnt
);

  localparam int unsigned LANES  = DATA_W / OUT_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  if (((DATA_W % OUT_W) != 0) || (DATA_W < OUT_W)) begin : g_width_check
    $error("fifo_rd_unpacker: DATA_W must be a non-zero multiple of OUT_W");
  end

  unpk_state_t       state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rden;
  logic              valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rden    = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        rden = i_en & ~i_fifo_empty;
        if (rden) state_d = WAIT;
      end
      // Read data arrives the cycle after rden; capture it unconditionally.
      WAIT: begin
        hold_d  = i_fifo_rddata;
        lane_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        valid = 1'b1;
        if (i_ready) begin
          if (lane_q == LAST_LANE) begin
            cnt_d   = cnt_q + CNT_W'(1);
            rden    = i_en & ~i_fifo_empty;
            state_d = rden ? WAIT : IDLE;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rden is a Mealy output, so it must be masked while the state is being reset.
  assign o_fifo_rden = rden & ~reset;
  assign o_valid     = valid;
  assign o_data      = hold_q[lane_q*OUT_W +: OUT_W];
  assign o_last      = valid & (lane_q == LAST_LANE);
  assign o_busy      = (state_q != IDLE);
  assign o_word_cnt  = cnt_q;

endmodule

// File: doc/fifo_rd_unpacker.md
Name: fifo_rd_unpacker

Overview:
- Read-side consumer of the 128-bit sync FIFO.
- Drives the FIFO read enable, captures each 128-bit read word into a holding register, and emits it as OUT_W-bit beats on a valid/ready stream, least-significant lane first.
- Sits directly downstream of the FIFO and feeds the narrow egress datapath.

Parameters:
- DATA_W, 128, FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 32, output beat width.
- LANES, DATA_W/OUT_W (derived, localparam), beats per FIFO word.
- CNT_W, 16, width of the drained-word counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_en  input  1  1 = new FIFO reads permitted; 0 = finish current word, issue no new reads.
- i_fifo_empty  input  1  FIFO o_empty.
- i_fifo_rddata  input  DATA_W  FIFO o_rddata.
- o_fifo_rden  output  1  FIFO i_rden.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream ready.
- o_data  output  OUT_W  output beat.
- o_last  output  1  beat is lane LANES-1 of its word.
- o_busy  output  1  state != IDLE.
- o_word_cnt  output  CNT_W  number of words fully drained; wraps modulo 2^CNT_W.

Behaviour:
- FIFO read timing (fixed): rden=1 sampled at edge E pops one word; o_rddata is valid in the cycle after E and is captured at edge E+1.
- State machine has three states: IDLE, WAIT, SEND.
- Registered state: state, hold[DATA_W], lane[clog2(LANES)], o_word_cnt.
- Reset (async assert): state=IDLE, hold=0, lane=0, o_word_cnt=0.
- During reset: o_valid=0, o_data=0, o_last=0, o_busy=0, o_fifo_rden=0.
- o_fifo_rden is a Mealy decode, forced to 0 while reset is high.
- IDLE:
  - o_fifo_rden = i_en & !i_fifo_empty.
  - If rden, go to WAIT; else stay in IDLE.
- WAIT:
  - o_valid=0, o_fifo_rden=0.
  - On the next edge: hold <= i_fifo_rddata, lane <= 0, go to SEND.
- SEND:
  - o_valid=1, o_data = hold[lane*OUT_W +: OUT_W], o_last = (lane==LANES-1).
  - Handshake is o_valid & i_ready.
  - No handshake: hold all state. o_data and o_last stay stable; o_valid is never withdrawn once asserted.
  - Handshake with lane < LANES-1: lane <= lane+1.
  - Handshake with lane == LANES-1: o_word_cnt increments. Then:
    - if i_en & !i_fifo_empty: o_fifo_rden=1 in the same cycle, go to WAIT;
    - else go to IDLE.
- Throughput: one bubble cycle between consecutive words, i.e. LANES beats per LANES+1 cycles with i_ready held high. No prefetch.
- First-beat latency from IDLE with a non-empty FIFO: rden at cycle t, o_valid at cycle t+2.
- Boundary conditions:
  - Never asserts rden while i_fifo_empty=1, so no FIFO underflow.
  - Never more than one read in flight.
  - i_en deasserted mid-word: current word drains fully, then the block goes to IDLE.
  - i_en deasserted in WAIT: the in-flight word is still captured and sent.
  - i_fifo_empty rising while in WAIT or SEND has no effect on the word in flight.
  - o_word_cnt wraps from 2^CNT_W-1 to 0.
  - Reset mid-word: partial word is discarded and no partial-word completion occurs. A pending read is dropped; the FIFO is reset on the same reset.
  - i_ready changes are acted on only in SEND; i_ready is ignored in IDLE and WAIT.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DATA_W=128, UNPK_OUT_W=32.
  - Enum unpk_state_t {IDLE, WAIT, SEND}.
- No sub-module; the lane mux is an indexed part-select inside the block.
- Elaboration-time assertion that DATA_W % OUT_W == 0.

Test Plan:
- Single word: FIFO holds 0x33333333_22222222_11111111_00000000, i_ready=1, i_en=1.
  - Expect rden for exactly 1 cycle.
  - Two cycles later, 4 beats in consecutive cycles: 0x00000000, 0x11111111, 0x22222222, 0x33333333, with o_last only on the 4th.
  - Then IDLE, and o_word_cnt=1.
- Back-to-back: 2 words preloaded, i_ready=1.
  - Expect 8 beats over 9 cycles with exactly one o_valid=0 bubble between beat 4 and beat 5.
  - Second rden coincides with the cycle of beat 4's handshake; o_word_cnt=2.
- Backpressure: i_ready=0 for 3 cycles on lane 2 of word 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
  - o_valid stays 1 and o_data holds 0xCCCCCCCC.
  - No rden, no lane advance; resumes with 0xDDDDDDDD and o_last=1.
- Empty / enable gating:
  - i_fifo_empty=1 for 20 cycles: rden never asserts and o_busy=0.
  - i_en dropped after beat 1 with 2 words queued: remaining 3 beats complete, then IDLE with no second rden.
- Reset mid-word: reset asserted asynchronously after beat 2.
  - o_valid, o_fifo_rden and o_busy go to 0 immediately; o_word_cnt=0.
  - After release with a new word queued, the first beat is lane 0 of the new word.
- Counter wrap: CNT_W=4, drain 17 words -> o_word_cnt reads 1.
